// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy
// count, programmable almost flags and sticky overflow/underflow.
module sync_fifo_fwft #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [DATA_WIDTH-1:0]   din,
  input  logic                    rd_en,
  input  logic                    clr_err,
  output logic [DATA_WIDTH-1:0]   dout,
  output logic                    full,
  output logic                    empty,
  output logic                    almost_full,
  output logic                    almost_empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, rd_ptr_nxt;
  logic                  rd_ok, wr_ok;

  // Extra pointer MSB separates full from empty, so count is a plain difference.
  assign count        = wr_ptr - rd_ptr;
  assign full         = (count == CW'(DEPTH));
  assign almost_full  = (count >= CW'(AF_THRESH));
  assign almost_empty = (count <= CW'(AE_THRESH));
  assign rd_ok        = rd_en && !empty;
  assign wr_ok        = wr_en && (!full || rd_ok);
  assign rd_ptr_nxt   = rd_ptr + CW'(rd_ok);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + CW'(1);
      rd_ptr <= rd_ptr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok && !rst) mem[wr_ptr[AW-1:0]] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && !wr_ok) overflow <= 1'b1;
      else if (clr_err)    overflow <= 1'b0;
      if (rd_en && !rd_ok) underflow <= 1'b1;
      else if (clr_err)    underflow <= 1'b0;
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      logic        vis;
      logic [AW:0] held;
      // Words already stored before this edge that survive the read; only those
      // may be staged, which gives the one-cycle write-to-visible latency.
      assign held  = count - CW'(rd_ok);
      assign empty = !vis;

      always_ff @(posedge clk) begin
        if (rst) begin
          vis  <= 1'b0;
          dout <= '0;
        end else begin
          vis <= (held != '0);
          if (held != '0) dout <= mem[rd_ptr_nxt[AW-1:0]];
        end
      end
    end else begin : g_std
      assign empty = (count == '0);

      always_ff @(posedge clk) begin
        if (rst)        dout <= '0;
        else if (rd_ok) dout <= mem[rd_ptr[AW-1:0]];
      end
    end
  endgenerate

endmodule
